uart_frame_packer: RTL and testbench

Parametrised successor to the single-channel SYNC/sample UART framer. Collects one ADC sample per channel from NUM_CH channels and snapshots the set once every channel holds a fresh sample. Serialises the snapshot as a framed byte stream (header, sequence number, full-width samples, optional XOR checksum) into the existing byte-wide UART transmitter. Fully synchronous; replaces the edge-triggered, 8-bit-truncating, header-once framer between the ADC front end and the UART TX.

---
 rtl/uart_frame_pkg.sv | 33 +++
 rtl/uart_frame_packer_if.sv | 22 ++
 rtl/uart_frame_sample_buf.sv | 68 ++++++
 rtl/uart_frame_packer.sv | 159 +++++++++++++++
 tb/tb_uart_frame_packer.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_frame_pkg.sv
// Shared constants, FSM state encoding and sizing helpers for the UART frame packer.
package uart_frame_pkg;

  localparam int HDR_LEN = 4;
  localparam logic [7:0] HDR_S = 8'h53;
  localparam logic [7:0] HDR_Y = 8'h59;
  localparam logic [7:0] HDR_N = 8'h4E;
  localparam logic [7:0] HDR_C = 8'h43;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_SEQ  = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4
  } state_e;

  function automatic int bytes_per_sample(input int w);
    return (w + 7) / 8;
  endfunction

  function automatic logic [7:0] hdr_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = HDR_S;
      2'd1:    b = HDR_Y;
      2'd2:    b = HDR_N;
      default: b = HDR_C;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_frame_packer_if.sv
// ADC sample strobe and UART byte handshake. A byte moves on the clk edge where
// tx_valid=1 and tx_busy=0; tx_data holds steady while tx_valid=1.
interface uart_frame_packer_if #(
  parameter int ADC_W = 12
);
  logic             adc_valid;
  logic [2:0]       adc_ch;
  logic [ADC_W-1:0] adc_value;
  logic             tx_busy;
  logic [7:0]       tx_data;
  logic             tx_valid;

  modport master (
    output adc_valid, adc_ch, adc_value, tx_busy,
    input  tx_data, tx_valid
  );

  modport slave (
    input  adc_valid, adc_ch, adc_value, tx_busy,
    output tx_data, tx_valid
  );
endinterface

// File: rtl/uart_frame_sample_buf.sv
// Per-channel hold/fresh/snapshot registers with sticky overrun detection.
module uart_frame_sample_buf #(
  parameter int NUM_CH = 2,
  parameter int ADC_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_valid_i,
  input  logic [2:0]        cap_ch_i,
  input  logic [ADC_W-1:0]  cap_value_i,
  input  logic              snap_take_i,
  output logic [ADC_W-1:0]  snap_o [NUM_CH],
  output logic              all_fresh_o,
  output logic              overrun_o,
  output logic [NUM_CH-1:0] fresh_o
);

  localparam logic [3:0] NUM_CH_L = 4'(NUM_CH);

  logic [ADC_W-1:0]  hold_q [NUM_CH];
  logic [ADC_W-1:0]  hold_d [NUM_CH];
  logic [ADC_W-1:0]  snap_q [NUM_CH];
  logic [ADC_W-1:0]  snap_d [NUM_CH];
  logic [NUM_CH-1:0] fresh_q, fresh_d;
  logic              overrun_q, overrun_d;
  logic              cap_hit;

  assign cap_hit = cap_valid_i && ({1'b0, cap_ch_i} < NUM_CH_L);

  // A capture in the snapshot cycle lands after the clear, so its fresh bit survives.
  always_comb begin
    hold_d    = hold_q;
    snap_d    = snap_q;
    fresh_d   = fresh_q;
    overrun_d = overrun_q;
    if (snap_take_i) begin
      snap_d  = hold_q;
      fresh_d = '0;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (cap_hit && (cap_ch_i == 3'(c))) begin
        hold_d[c]  = cap_value_i;
        fresh_d[c] = 1'b1;
        if (fresh_q[c] && !snap_take_i) overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q    <= '{default: '0};
      snap_q    <= '{default: '0};
      fresh_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      snap_q    <= snap_d;
      fresh_q   <= fresh_d;
      overrun_q <= overrun_d;
    end
  end

  assign snap_o      = snap_q;
  assign all_fresh_o = &fresh_q;
  assign overrun_o   = overrun_q;
  assign fresh_o     = fresh_q;

endmodule

// File: rtl/uart_frame_packer.sv
// Snapshots one sample per channel and serialises SYNC header, sequence number,
// MSB-first samples and optional XOR checksum into a byte-wide UART handshake.
module uart_frame_packer
  import uart_frame_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int ADC_W       = 12,
  parameter bit CHECKSUM_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  uart_frame_packer_if.slave  bus,
  output logic                frame_busy,
  output logic                overrun,
  output logic [7:0]          seq,
  output state_e              state_dbg,
  output logic [NUM_CH-1:0]   fresh_dbg
);

  localparam int SB = bytes_per_sample(ADC_W);
  localparam int NB = NUM_CH * SB;
  localparam int CW = 5;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       csum_q, csum_d;
  logic [7:0]       seq_q, seq_d;
  logic             snap_take;
  logic             all_fresh;
  logic [ADC_W-1:0] snap [NUM_CH];
  logic [NB*8-1:0]  data_vec;
  logic [7:0]       data_byte;
  logic [7:0]       tx_data_c;
  logic             tx_valid_c;
  logic             xfer;

  uart_frame_sample_buf #(
    .NUM_CH(NUM_CH),
    .ADC_W (ADC_W)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .cap_valid_i (bus.adc_valid),
    .cap_ch_i    (bus.adc_ch),
    .cap_value_i (bus.adc_value),
    .snap_take_i (snap_take),
    .snap_o      (snap),
    .all_fresh_o (all_fresh),
    .overrun_o   (overrun),
    .fresh_o     (fresh_dbg)
  );

  // Channel 0 occupies the top slot; each sample sits zero-extended in its SB-byte slot.
  always_comb begin
    data_vec  = '0;
    data_byte = 8'h00;
    for (int c = 0; c < NUM_CH; c++) begin
      data_vec[(NUM_CH-1-c)*SB*8 +: ADC_W] = snap[c];
    end
    for (int b = 0; b < NB; b++) begin
      if (cnt_q == CW'(b)) data_byte = data_vec[(NB-1-b)*8 +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    csum_d     = csum_q;
    seq_d      = seq_q;
    snap_take  = 1'b0;
    tx_data_c  = 8'h00;
    tx_valid_c = 1'b0;
    xfer       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && all_fresh) begin
          snap_take = 1'b1;
          csum_d    = 8'h00;
          cnt_d     = '0;
          state_d   = ST_HDR;
        end
      end
      ST_HDR: begin
        tx_valid_c = 1'b1;
        tx_data_c  = hdr_byte(cnt_q[1:0]);
        xfer       = !bus.tx_busy;
        if (xfer) begin
          if (cnt_q == CW'(HDR_LEN-1)) begin
            cnt_d   = '0;
            state_d = ST_SEQ;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_SEQ: begin
        tx_valid_c = 1'b1;
        tx_data_c  = seq_q;
        xfer       = !bus.tx_busy;
        if (xfer) begin
          csum_d  = csum_q ^ seq_q;
          cnt_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_valid_c = 1'b1;
        tx_data_c  = data_byte;
        xfer       = !bus.tx_busy;
        if (xfer) begin
          csum_d = csum_q ^ data_byte;
          if (cnt_q == CW'(NB-1)) begin
            cnt_d = '0;
            if (CHECKSUM_EN) begin
              state_d = ST_CSUM;
            end else begin
              seq_d   = seq_q + 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_CSUM: begin
        tx_valid_c = 1'b1;
        tx_data_c  = csum_q;
        xfer       = !bus.tx_busy;
        if (xfer) begin
          seq_d   = seq_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      csum_q  <= 8'h00;
      seq_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      seq_q   <= seq_d;
    end
  end

  assign bus.tx_data  = tx_data_c;
  assign bus.tx_valid = tx_valid_c;
  assign frame_busy   = (state_q != ST_IDLE);
  assign seq          = seq_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_uart_frame_packer.sv
// Directed bench: default 2x12-bit packer with checksum, plus a 1x8-bit packer without checksum.
module tb_uart_frame_packer;
  import uart_frame_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_enable = 1'b0;
  logic b_enable = 1'b0;

  logic       a_frame_busy, a_overrun;
  logic [7:0] a_seq;
  state_e     a_state;
  logic [1:0] a_fresh;
  logic       b_frame_busy, b_overrun;
  logic [7:0] b_seq;
  state_e     b_state;
  logic [0:0] b_fresh;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_a[$];
  logic [7:0] got_b[$];

  uart_frame_packer_if #(.ADC_W(12)) a_bus ();
  uart_frame_packer_if #(.ADC_W(8))  b_bus ();

  uart_frame_packer #(.NUM_CH(2), .ADC_W(12), .CHECKSUM_EN(1'b1)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .enable     (a_enable),
    .bus        (a_bus),
    .frame_busy (a_frame_busy),
    .overrun    (a_overrun),
    .seq        (a_seq),
    .state_dbg  (a_state),
    .fresh_dbg  (a_fresh)
  );

  uart_frame_packer #(.NUM_CH(1), .ADC_W(8), .CHECKSUM_EN(1'b0)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .enable     (b_enable),
    .bus        (b_bus),
    .frame_busy (b_frame_busy),
    .overrun    (b_overrun),
    .seq        (b_seq),
    .state_dbg  (b_state),
    .fresh_dbg  (b_fresh)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Inputs change 1 time unit after posedge, so the negedge view equals what the next posedge sees.
  always @(negedge clk) begin
    if (a_bus.tx_valid && !a_bus.tx_busy) got_a.push_back(a_bus.tx_data);
    if (b_bus.tx_valid && !b_bus.tx_busy) got_b.push_back(b_bus.tx_data);
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_bus.adc_valid = 1'b0; a_bus.adc_ch = 3'd0; a_bus.adc_value = '0; a_bus.tx_busy = 1'b0;
    b_bus.adc_valid = 1'b0; b_bus.adc_ch = 3'd0; b_bus.adc_value = '0; b_bus.tx_busy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    got_a.delete();
    got_b.delete();
  endtask

  task automatic strobe_a(input logic [2:0] ch, input logic [11:0] val);
    a_bus.adc_valid = 1'b1;
    a_bus.adc_ch    = ch;
    a_bus.adc_value = val;
    tick();
    a_bus.adc_valid = 1'b0;
  endtask

  task automatic strobe_b(input logic [7:0] val);
    b_bus.adc_valid = 1'b1;
    b_bus.adc_ch    = 3'd0;
    b_bus.adc_value = val;
    tick();
    b_bus.adc_valid = 1'b0;
  endtask

  task automatic wait_frame_a(output int busy_cycles);
    busy_cycles = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (a_frame_busy) busy_cycles++;
      else if (busy_cycles > 0) break;
    end
  endtask

  task automatic wait_frame_b(output int busy_cycles);
    busy_cycles = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (b_frame_busy) busy_cycles++;
      else if (busy_cycles > 0) break;
    end
  endtask

  // tests
  task automatic test_reset();
    do_reset();
    total++; if (a_bus.tx_valid !== 1'b0) begin bad++; $display("FAIL rst_tx_valid got=%b exp=0", a_bus.tx_valid); end
    total++; if (a_bus.tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data got=%02h exp=00", a_bus.tx_data); end
    total++; if (a_frame_busy !== 1'b0) begin bad++; $display("FAIL rst_frame_busy got=%b exp=0", a_frame_busy); end
    total++; if (a_overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun got=%b exp=0", a_overrun); end
    total++; if (a_seq !== 8'h00) begin bad++; $display("FAIL rst_seq got=%02h exp=00", a_seq); end
    total++; if (a_fresh !== 2'b00) begin bad++; $display("FAIL rst_fresh got=%b exp=00", a_fresh); end
    total++; if (a_state !== ST_IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", a_state, ST_IDLE); end
    total++; if (b_bus.tx_valid !== 1'b0 || b_seq !== 8'h00) begin bad++; $display("FAIL rst_b got valid=%b seq=%02h exp 0/00", b_bus.tx_valid, b_seq); end
  endtask

  task automatic test_basic_frame();
    int bc;
    do_reset();
    a_enable = 1'b1;
    strobe_a(3'd0, 12'hABC);
    strobe_a(3'd1, 12'h123);
    wait_frame_a(bc);
    exp_q = '{8'h53, 8'h59, 8'h4E, 8'h43, 8'h00, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h94};
    total++; if (got_a.size() != exp_q.size()) begin bad++; $display("FAIL basic_len got=%0d exp=%0d", got_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
      total++; if (got_a[i] !== exp_q[i]) begin bad++; $display("FAIL basic_byte%0d got=%02h exp=%02h", i, got_a[i], exp_q[i]); end
    end
    total++; if (bc != 10) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=10", bc); end
    total++; if (a_seq !== 8'h01) begin bad++; $display("FAIL basic_seq got=%02h exp=01", a_seq); end
    total++; if (a_frame_busy !== 1'b0 || a_bus.tx_valid !== 1'b0) begin bad++; $display("FAIL basic_idle got busy=%b valid=%b exp 0/0", a_frame_busy, a_bus.tx_valid); end
    total++; if (a_overrun !== 1'b0) begin bad++; $display("FAIL basic_overrun got=%b exp=0", a_overrun); end
  endtask

  task automatic test_stall();
    int  bc;
    bit  found;
    do_reset();
    a_enable = 1'b1;
    strobe_a(3'd0, 12'hABC);
    strobe_a(3'd1, 12'h123);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (a_state == ST_DATA && a_bus.tx_data == 8'h0A) begin
        found = 1'b1;
        break;
      end
    end
    a_bus.tx_busy = 1'b1;
    total++; if (!found) begin bad++; $display("FAIL stall_reach_data got=timeout exp=data byte 0A"); end
    for (int i = 0; i < 20; i++) begin
      tick();
      total++; if (a_bus.tx_valid !== 1'b1 || a_bus.tx_data !== 8'h0A) begin bad++; $display("FAIL stall_hold%0d got valid=%b data=%02h exp 1/0A", i, a_bus.tx_valid, a_bus.tx_data); end
    end
    a_bus.tx_busy = 1'b0;
    wait_frame_a(bc);
    exp_q = '{8'h53, 8'h59, 8'h4E, 8'h43, 8'h00, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h94};
    total++; if (got_a.size() != exp_q.size()) begin bad++; $display("FAIL stall_len got=%0d exp=%0d", got_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
      total++; if (got_a[i] !== exp_q[i]) begin bad++; $display("FAIL stall_byte%0d got=%02h exp=%02h", i, got_a[i], exp_q[i]); end
    end
  endtask

  task automatic test_overrun();
    int bc;
    do_reset();
    a_enable = 1'b1;
    strobe_a(3'd0, 12'h111);
    total++; if (a_overrun !== 1'b0) begin bad++; $display("FAIL ovr_first got=%b exp=0", a_overrun); end
    strobe_a(3'd0, 12'h222);
    total++; if (a_overrun !== 1'b1) begin bad++; $display("FAIL ovr_second got=%b exp=1", a_overrun); end
    strobe_a(3'd1, 12'h333);
    wait_frame_a(bc);
    exp_q = '{8'h53, 8'h59, 8'h4E, 8'h43, 8'h00, 8'h02, 8'h22, 8'h03, 8'h33, 8'h10};
    total++; if (got_a.size() != exp_q.size()) begin bad++; $display("FAIL ovr_len got=%0d exp=%0d", got_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
      total++; if (got_a[i] !== exp_q[i]) begin bad++; $display("FAIL ovr_byte%0d got=%02h exp=%02h", i, got_a[i], exp_q[i]); end
    end
    total++; if (a_overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b exp=1", a_overrun); end
  endtask

  task automatic test_snapshot_collision();
    int bc;
    bit busy_seen;
    do_reset();
    a_enable = 1'b1;
    strobe_a(3'd0, 12'h0AB);
    a_bus.adc_valid = 1'b1; a_bus.adc_ch = 3'd1; a_bus.adc_value = 12'h0CD;
    tick();
    a_bus.adc_ch = 3'd0; a_bus.adc_value = 12'h456;
    tick();
    a_bus.adc_valid = 1'b0;
    total++; if (a_fresh !== 2'b01) begin bad++; $display("FAIL coll_fresh_after_snap got=%b exp=01", a_fresh); end
    total++; if (a_overrun !== 1'b0) begin bad++; $display("FAIL coll_overrun got=%b exp=0", a_overrun); end
    wait_frame_a(bc);
    exp_q = '{8'h53, 8'h59, 8'h4E, 8'h43, 8'h00, 8'h00, 8'hAB, 8'h00, 8'hCD, 8'h66};
    total++; if (got_a.size() != exp_q.size()) begin bad++; $display("FAIL coll_len got=%0d exp=%0d", got_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
      total++; if (got_a[i] !== exp_q[i]) begin bad++; $display("FAIL coll_byte%0d got=%02h exp=%02h", i, got_a[i], exp_q[i]); end
    end
    total++; if (a_fresh !== 2'b01) begin bad++; $display("FAIL coll_fresh_kept got=%b exp=01", a_fresh); end
    busy_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (a_frame_busy) busy_seen = 1'b1;
    end
    total++; if (busy_seen) begin bad++; $display("FAIL coll_no_early_frame got=busy exp=idle"); end
    got_a.delete();
    strobe_a(3'd1, 12'h789);
    wait_frame_a(bc);
    exp_q = '{8'h53, 8'h59, 8'h4E, 8'h43, 8'h01, 8'h04, 8'h56, 8'h07, 8'h89, 8'hDD};
    total++; if (got_a.size() != exp_q.size()) begin bad++; $display("FAIL coll2_len got=%0d exp=%0d", got_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
      total++; if (got_a[i] !== exp_q[i]) begin bad++; $display("FAIL coll2_byte%0d got=%02h exp=%02h", i, got_a[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int bc;
    bit found;
    do_reset();
    a_enable = 1'b1;
    strobe_a(3'd7, 12'h5A5);
    strobe_a(3'd2, 12'h5A5);
    total++; if (a_fresh !== 2'b00) begin bad++; $display("FAIL rmf_bad_ch_ignored got=%b exp=00", a_fresh); end
    strobe_a(3'd0, 12'h001);
    strobe_a(3'd0, 12'h002);
    strobe_a(3'd1, 12'h003);
    wait_frame_a(bc);
    total++; if (a_seq !== 8'h01 || a_overrun !== 1'b1) begin bad++; $display("FAIL rmf_setup got seq=%02h ovr=%b exp 01/1", a_seq, a_overrun); end
    strobe_a(3'd0, 12'h004);
    strobe_a(3'd1, 12'h005);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (a_state == ST_SEQ) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    total++; if (!found) begin bad++; $display("FAIL rmf_reach_seq got=timeout exp=SEQ state"); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (a_bus.tx_valid !== 1'b0) begin bad++; $display("FAIL rmf_tx_valid got=%b exp=0", a_bus.tx_valid); end
    total++; if (a_seq !== 8'h00) begin bad++; $display("FAIL rmf_seq got=%02h exp=00", a_seq); end
    total++; if (a_overrun !== 1'b0) begin bad++; $display("FAIL rmf_overrun got=%b exp=0", a_overrun); end
    total++; if (a_frame_busy !== 1'b0 || a_fresh !== 2'b00) begin bad++; $display("FAIL rmf_idle got busy=%b fresh=%b exp 0/00", a_frame_busy, a_fresh); end
    got_a.delete();
    strobe_a(3'd0, 12'hFFF);
    strobe_a(3'd1, 12'h000);
    wait_frame_a(bc);
    exp_q = '{8'h53, 8'h59, 8'h4E, 8'h43, 8'h00, 8'h0F, 8'hFF, 8'h00, 8'h00, 8'hF0};
    total++; if (got_a.size() != exp_q.size()) begin bad++; $display("FAIL rmf_len got=%0d exp=%0d", got_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
      total++; if (got_a[i] !== exp_q[i]) begin bad++; $display("FAIL rmf_byte%0d got=%02h exp=%02h", i, got_a[i], exp_q[i]); end
    end
  endtask

  task automatic test_small_config();
    int bc;
    bit busy_seen;
    do_reset();
    a_enable = 1'b0;
    b_enable = 1'b0;
    strobe_b(8'h7F);
    busy_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (b_frame_busy) busy_seen = 1'b1;
    end
    total++; if (busy_seen || got_b.size() != 0) begin bad++; $display("FAIL small_disabled got busy=%b bytes=%0d exp 0/0", busy_seen, got_b.size()); end
    total++; if (b_fresh !== 1'b1) begin bad++; $display("FAIL small_fresh got=%b exp=1", b_fresh); end
    b_enable = 1'b1;
    wait_frame_b(bc);
    exp_q = '{8'h53, 8'h59, 8'h4E, 8'h43, 8'h00, 8'h7F};
    total++; if (got_b.size() != exp_q.size()) begin bad++; $display("FAIL small_len got=%0d exp=%0d", got_b.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_b.size(); i++) begin
      total++; if (got_b[i] !== exp_q[i]) begin bad++; $display("FAIL small_byte%0d got=%02h exp=%02h", i, got_b[i], exp_q[i]); end
    end
    total++; if (bc != 6) begin bad++; $display("FAIL small_busy_cycles got=%0d exp=6", bc); end
    total++; if (b_seq !== 8'h01) begin bad++; $display("FAIL small_seq got=%02h exp=01", b_seq); end
    for (int i = 1; i < 256; i++) begin
      got_b.delete();
      strobe_b(8'(i));
      wait_frame_b(bc);
      total++;
      if (got_b.size() != 6 || got_b[4] !== 8'(i) || got_b[5] !== 8'(i)) begin
        bad++;
        $display("FAIL small_wrap_frame%0d got len=%0d seq=%02h data=%02h exp 6/%02h/%02h", i, got_b.size(), got_b[4], got_b[5], 8'(i), 8'(i));
      end
    end
    total++; if (b_seq !== 8'h00) begin bad++; $display("FAIL small_seq_wrap got=%02h exp=00", b_seq); end
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_basic_frame();
    test_stall();
    test_overrun();
    test_snapshot_collision();
    test_reset_mid_frame();
    test_small_config();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
